// File: rtl/toggle_edge_detector.sv
// Turns a toggle-encoded level into a one-cycle event pulse.
// previous_state follows toggle_state every cycle, reset included, so a release never fakes an event.
module toggle_edge_detector (
   input  logic clock,
   input  logic reset,
   input  logic toggle_state,
   output logic event_pulse
);

   logic previous_state;

   // reset is accepted for interface uniformity; previous_state must track the input through it.
   logic unused_reset;
   assign unused_reset = reset;

   always_ff @(posedge clock) begin
      previous_state <= toggle_state;
   end

   assign event_pulse = toggle_state ^ previous_state;

endmodule

// File: rtl/toggle_event_collector.sv
// Collects toggle events into a saturating pending counter drained by a valid/ready consumer.
// Handshake: one event is dequeued on each rising edge where event_valid and event_ready are both high.
module toggle_event_collector #(
   parameter int COUNTER_WIDTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     toggle_state,
   output logic                     event_valid,
   input  logic                     event_ready,
   output logic [COUNTER_WIDTH-1:0] pending_count,
   output logic                     overflow,
   input  logic                     clear_overflow
);

   localparam logic [COUNTER_WIDTH-1:0] count_max = '1;
   localparam logic [COUNTER_WIDTH-1:0] count_one = COUNTER_WIDTH'(1);

   logic                     event_pulse;
   logic                     handshake;
   logic [COUNTER_WIDTH-1:0] next_count;
   logic                     next_overflow;

   toggle_edge_detector u_edge (
      .clock        (clock),
      .reset        (reset),
      .toggle_state (toggle_state),
      .event_pulse  (event_pulse)
   );

   // event_valid is registered, so a low valid blocks ready and the count never underflows.
   assign handshake = event_valid & event_ready;

   always_comb begin
      next_count    = pending_count;
      next_overflow = overflow & ~clear_overflow;
      case ({event_pulse, handshake})
         2'b10: begin
            if (pending_count == count_max) begin
               next_overflow = 1'b1;
            end else begin
               next_count = pending_count + count_one;
            end
         end
         2'b01:   next_count = pending_count - count_one;
         default: next_count = pending_count;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending_count <= '0;
         event_valid   <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         pending_count <= next_count;
         event_valid   <= (next_count != '0);
         overflow      <= next_overflow;
      end
   end

endmodule

// File: tb/tb_toggle_event_collector.sv
// Directed and randomized checks of toggle_event_collector (width 2) against an arithmetic reference model.
module tb_toggle_event_collector;

   localparam int W   = 2;
   localparam int MAX = (1 << W) - 1;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         toggle_state = 1'b0;
   logic         event_valid;
   logic         event_ready = 1'b0;
   logic [W-1:0] pending_count;
   logic         overflow;
   logic         clear_overflow = 1'b0;

   int checks_made = 0;
   int checks_failed = 0;

   // model state
   int   model_count = 0;
   bit   model_overflow = 1'b0;
   logic model_prev = 1'b0;
   logic [W:0] exp_q[$];

   toggle_event_collector #(.COUNTER_WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .toggle_state   (toggle_state),
      .event_valid    (event_valid),
      .event_ready    (event_ready),
      .pending_count  (pending_count),
      .overflow       (overflow),
      .clear_overflow (clear_overflow)
   );

   always #5 clock = ~clock;

   task automatic check_value(input string tag, input int actual, input int expected);
      checks_made++;
      if (actual !== expected) begin
         checks_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Reference: count events and handshakes as integers, clamp at MAX and flag the loss.
   task automatic model_edge(input logic t, input logic rdy, input logic clr, input logic rst);
      int delta;
      bit lost;
      if (rst) begin
         model_count    = 0;
         model_overflow = 1'b0;
      end else begin
         delta = ((t != model_prev) ? 1 : 0) - ((rdy && model_count > 0) ? 1 : 0);
         lost  = (model_count + delta > MAX);
         if (!lost) model_count = model_count + delta;
         model_overflow = (clr ? 1'b0 : model_overflow) | lost;
      end
      model_prev = t;
      exp_q.push_back({model_overflow, W'(model_count)});
   endtask

   task automatic drive_cycle(input logic t, input logic rdy, input logic clr, input logic rst,
                              input string tag);
      logic [W:0] exp;
      toggle_state   = t;
      event_ready    = rdy;
      clear_overflow = clr;
      reset          = rst;
      @(posedge clock);
      model_edge(t, rdy, clr, rst);
      #1;
      exp = exp_q.pop_front();
      check_value({tag, "_count"},    int'(pending_count), int'(exp[W-1:0]));
      check_value({tag, "_valid"},    int'(event_valid),   int'(exp[W-1:0] != '0));
      check_value({tag, "_overflow"}, int'(overflow),      int'(exp[W]));
   endtask

   initial begin
      // reset with toggle low
      repeat (3) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, "reset");
      check_value("reset_count_const", int'(pending_count), 0);

      // single event, then drain
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, "single_up");
      check_value("single_up_const", int'(pending_count), 1);
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, "single_drain");
      check_value("single_drain_const", int'(event_valid), 0);
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, "ready_when_empty");

      // reset with toggle held high, and a level change swallowed by reset
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, "reset_hi_a");
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, "reset_hi_b");
      repeat (5) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, "release_hold");
      check_value("release_hold_const", int'(pending_count), 0);

      // saturation: four toggles into a width-2 counter
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, "sat_1");
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, "sat_2");
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, "sat_3");
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, "sat_4");
      check_value("sat_count_const", int'(pending_count), 3);
      check_value("sat_overflow_const", int'(overflow), 1);
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, "clear_ovf");
      check_value("clear_ovf_const", int'(overflow), 0);

      // full + toggle + ready: unchanged, no overflow
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, "full_simul");
      check_value("full_simul_count", int'(pending_count), 3);
      check_value("full_simul_ovf", int'(overflow), 0);

      // set wins over clear
      drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, "set_wins");
      check_value("set_wins_const", int'(overflow), 1);

      // count 2, toggle + ready
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, "down_to_2");
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, "simul_at_2");
      check_value("simul_at_2_const", int'(pending_count), 2);

      // random soak with a mid-run reset
      for (int i = 0; i < 1000; i++) begin
         logic t;
         t = ($urandom_range(1, 0) == 1) ? ~toggle_state : toggle_state;
         if (i == 500) begin
            drive_cycle(t, 1'b0, 1'b0, 1'b1, "soak_reset");
            check_value("soak_reset_const", int'(pending_count), 0);
         end else begin
            drive_cycle(t, ($urandom_range(9, 0) < 3), ($urandom_range(19, 0) == 0),
                        1'b0, "soak");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks_made, checks_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/toggle_event_collector.md
TOGGLE_EVENT_COLLECTOR -- requirements
Module: toggle_event_collector

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 4, giving the width of the pending-event counter (legal range 1..16).
REQ-002 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port toggle_state, input, 1, the toggle-encoded event stream from a toggle flip-flop; each level change is one event.
REQ-005 SHALL have port event_valid, output, 1, high while at least one event is pending.
REQ-006 SHALL have port event_ready, input, 1, consumer acceptance; valid and ready high on the same edge dequeues one event.
REQ-007 SHALL have port pending_count, output, COUNTER_WIDTH, the number of pending events.
REQ-008 SHALL have port overflow, output, 1, sticky flag for a lost event.
REQ-009 SHALL have port clear_overflow, input, 1, which clears overflow on the next edge.

Function
REQ-010 SHALL register toggle_state into previous_state every cycle, including during reset.
REQ-011 SHALL detect an event on an edge where toggle_state differs from previous_state.
REQ-012 SHALL make event_valid, pending_count and overflow registered outputs; event_valid equals (pending_count != 0).
REQ-013 SHALL give one cycle of latency: a toggle_state change sampled at edge N raises event_valid after edge N.
REQ-014 SHALL update the counter as follows: detect only gives +1; handshake only gives -1; detect and handshake on the same edge leave it unchanged.
REQ-015 SHALL hold the counter at 2^COUNTER_WIDTH-1 when it is full and an event arrives with no handshake; that event is dropped and overflow is set.
REQ-016 SHALL treat full plus detect plus handshake as the unchanged case, with no overflow.
REQ-017 SHALL ignore event_ready while event_valid is low; the counter never wraps below 0.
REQ-018 SHALL let set win when clear_overflow and a new overflow occur on the same edge.
REQ-019 SHALL count at most one event per cycle; a level that changes and returns between two edges is invisible (upstream guarantees at most one toggle per cycle).
REQ-020 SHALL have no combinational path from any input to any output.

Reset
REQ-021 SHALL, with reset high at an edge, drive pending_count=0, event_valid=0 and overflow=0, and load previous_state from toggle_state so that no spurious event occurs at release.
REQ-022 SHALL discard events pending at a mid-operation reset, and discard a toggle_state change sampled during reset.
REQ-023 SHALL make reset take priority over detection, handshake and clear_overflow.

Structure
REQ-024 SHALL need no shared package; the counter maximum is a localparam derived from COUNTER_WIDTH.
REQ-025 SHALL place edge detection in one sub-module, toggle_edge_detector (clock, reset, toggle_state -> event_pulse), which owns previous_state.
REQ-026 SHALL contain only the saturating up/down counter, the overflow flag and the output registers in the top level.

Verification
REQ-027 SHALL cover single event: after reset toggle_state 0->1, ready=0 -> pending_count=1 and event_valid=1 one cycle later; ready=1 for one cycle -> count=0, valid=0.
REQ-028 SHALL cover reset release with toggle_state held at 1: 5 cycles with no change -> count stays 0 and valid stays 0.
REQ-029 SHALL cover saturation with COUNTER_WIDTH=2: toggle 4 times with ready=0 -> count=3 and overflow=1 after the 4th; clear_overflow pulse -> overflow=0 and count=3.
REQ-030 SHALL cover simultaneity: count=2, toggle plus ready on the same edge -> count stays 2; count=3 (full, width 2) with toggle plus ready -> count=3 and overflow=0.
REQ-031 SHALL cover set-wins: full counter, toggle with ready=0 and clear_overflow=1 on the same edge -> overflow=1.
REQ-032 SHALL cover random soak: 1000 cycles of random toggles (p=0.5) and ready (p=0.3) checked against a reference model of count and overflow, plus a mid-run reset -> count=0 the next cycle.
